// File: rtl/dbus_sram_slave.sv
// Single-ported 64-bit data RAM on the CPU data bus: zero-fills after reset, then serves
// byte-masked stores through a one-entry write buffer and right-aligned loads with forwarding.
module dbus_sram_slave #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dbus_ena_i,
  input  logic [7:0]  dbus_wea_i,
  input  logic [2:0]  dbus_rlen_i,
  input  logic [63:0] dbus_addr_i,
  input  logic [63:0] dbus_wdata_i,
  output logic [63:0] dbus_rdata_o,
  output logic        ready_o,
  output logic        misalign_o
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  logic          run;
  logic [63:0]   req_off;
  logic          req_in_win;
  logic [AW-1:0] req_idx;
  logic          is_load, is_store;
  logic [3:0]    ld_span;

  assign run        = (state_q == RUN);
  assign req_off    = dbus_addr_i - BASE_ADDR;
  assign req_in_win = ((req_off >> (AW + 3)) == 64'd0);
  assign req_idx    = req_off[AW+2:3];
  assign is_load    = run && dbus_ena_i && (dbus_wea_i == 8'd0);
  assign is_store   = run && dbus_ena_i && (dbus_wea_i != 8'd0);
  assign ld_span    = {1'b0, dbus_addr_i[2:0]} + {1'b0, dbus_rlen_i};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (&idx_q) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // One-entry write buffer; commits on the cycle after capture
  logic          buf_v_q, buf_v_d;
  logic [AW-1:0] buf_idx_q;
  logic [7:0]    buf_mask_q;
  logic [63:0]   buf_data_q;

  assign buf_v_d = is_store && req_in_win;

  always_ff @(posedge clk) begin
    if (!resetn) buf_v_q <= 1'b0;
    else         buf_v_q <= buf_v_d;
    if (is_store) begin
      buf_idx_q  <= req_idx;
      buf_mask_q <= dbus_wea_i;
      buf_data_q <= dbus_wdata_i;
    end
  end

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_mask;
  logic [63:0]   wr_data;

  // Shared write port: zero-fill during CLEAR, buffer commit during RUN; reset blocks both
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_mask = 8'hFF;
    wr_data = '0;
    if (!run) begin
      wr_en = resetn;
    end else if (buf_v_q) begin
      wr_en   = resetn;
      wr_idx  = buf_idx_q;
      wr_mask = buf_mask_q;
      wr_data = buf_data_q;
    end
  end

  logic [63:0] mem [DEPTH];
  logic [63:0] ram_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    ram_q <= mem[req_idx];
  end

  // Load stage 1: snapshot the buffer lanes that are newer than the array read
  logic        ld_v_q, ld_win_q, misalign_q;
  logic [2:0]  ld_off_q, ld_rlen_q;
  logic [7:0]  fwd_mask_q, fwd_mask_d;
  logic [63:0] fwd_data_q;

  assign fwd_mask_d = (buf_v_q && (buf_idx_q == req_idx)) ? buf_mask_q : 8'd0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ld_v_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      ld_v_q <= is_load;
      if (is_load && (ld_span > 4'd7)) misalign_q <= 1'b1;
    end
    if (is_load) begin
      ld_win_q   <= req_in_win;
      ld_off_q   <= dbus_addr_i[2:0];
      ld_rlen_q  <= dbus_rlen_i;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= buf_data_q;
    end
  end

  // Load stage 2: merge, right-align, trim to length
  logic [63:0] merged, shifted, masked, rdata_q, rdata_d;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign merged[8*gi +: 8] = fwd_mask_q[gi] ? fwd_data_q[8*gi +: 8] : ram_q[8*gi +: 8];
    assign masked[8*gi +: 8] = (3'(gi) <= ld_rlen_q) ? shifted[8*gi +: 8] : 8'd0;
  end

  assign shifted = merged >> {ld_off_q, 3'b000};
  assign rdata_d = ld_win_q ? masked : 64'd0;

  always_ff @(posedge clk) begin
    if (!resetn)     rdata_q <= '0;
    else if (ld_v_q) rdata_q <= rdata_d;
  end

  assign dbus_rdata_o = rdata_q;
  assign ready_o      = run;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_dbus_sram_slave.sv
// Directed and randomized bench for dbus_sram_slave (16-word array); load results are
// predicted by a byte-level memory model and matched through an in-order scoreboard.
module tb_dbus_sram_slave;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dbus_ena_i;
  logic [7:0]  dbus_wea_i;
  logic [2:0]  dbus_rlen_i;
  logic [63:0] dbus_addr_i;
  logic [63:0] dbus_wdata_i;
  logic [63:0] dbus_rdata_o;
  logic        ready_o;
  logic        misalign_o;

  dbus_sram_slave #(.DEPTH_LOG2(4), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .dbus_ena_i   (dbus_ena_i),
    .dbus_wea_i   (dbus_wea_i),
    .dbus_rlen_i  (dbus_rlen_i),
    .dbus_addr_i  (dbus_addr_i),
    .dbus_wdata_i (dbus_wdata_i),
    .dbus_rdata_o (dbus_rdata_o),
    .ready_o      (ready_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];
  string       tag_q [$];
  logic [63:0] model [16];
  logic        load_now = 1'b0;
  logic        pend1 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; the load sampled on the previous edge is due now
  task automatic step();
    logic        lat;
    logic [63:0] e;
    string       t;
    @(posedge clk);
    lat   = pend1;
    pend1 = load_now;
    #1;
    if (lat) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL scoreboard: observed load with no expectation, rdata %h", dbus_rdata_o);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, dbus_rdata_o, e);
      end
    end
  endtask

  function automatic logic [63:0] mload(input logic [63:0] a, input logic [2:0] rl);
    logic [63:0] d, w, r;
    int o;
    d = a - BASE;
    r = '0;
    if (d >= 64'd128) return '0;
    w = model[d[6:3]];
    o = int'(a[2:0]);
    for (int b = 0; b < 8; b++)
      if (b <= int'(rl) && o + b <= 7) r[8*b +: 8] = w[8*(o+b) +: 8];
    return r;
  endfunction

  task automatic load(input logic [63:0] a, input logic [2:0] rl, input logic [63:0] exp,
                      input string tag);
    dbus_ena_i  = 1'b1;
    dbus_wea_i  = 8'd0;
    dbus_addr_i = a;
    dbus_rlen_i = rl;
    load_now    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    load_now    = 1'b0;
  endtask

  task automatic store(input logic [63:0] a, input logic [7:0] we, input logic [63:0] data);
    logic [63:0] d;
    dbus_ena_i   = 1'b1;
    dbus_wea_i   = we;
    dbus_addr_i  = a;
    dbus_wdata_i = data;
    d = a - BASE;
    if (d < 64'd128)
      for (int b = 0; b < 8; b++)
        if (we[b]) model[d[6:3]][8*b +: 8] = data[8*b +: 8];
    step();
  endtask

  task automatic idle(input int n);
    dbus_ena_i = 1'b0;
    dbus_wea_i = 8'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [2:0]  rl_tab [4];
  logic [63:0] a;
  logic [7:0]  we;
  logic [2:0]  rl;
  int          cnt;

  initial begin
    rl_tab = '{3'd0, 3'd1, 3'd3, 3'd7};
    for (int i = 0; i < 16; i++) model[i] = '0;
    resetn = 1'b0; dbus_ena_i = 1'b0; dbus_wea_i = 8'd0;
    dbus_rlen_i = 3'd0; dbus_addr_i = BASE; dbus_wdata_i = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rdata", dbus_rdata_o, 64'd0);
      chk("rst_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_misalign", {63'd0, misalign_o}, 64'd0);
    end

    // Release; a store held during CLEAR must be ignored
    resetn = 1'b1;
    dbus_ena_i = 1'b1; dbus_wea_i = 8'hFF; dbus_addr_i = BASE + 64'd24;
    dbus_wdata_i = 64'hFFFF_EEEE_DDDD_CCCC;
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("clear_ready_%0d", i + 1), {63'd0, ready_o}, 64'd0);
    end
    dbus_ena_i = 1'b0; dbus_wea_i = 8'd0;
    step();
    chk("ready_rise", {63'd0, ready_o}, 64'd1);

    load(BASE, 3'd7, 64'd0, "load_after_clear");
    load(BASE + 64'd24, 3'd7, 64'd0, "store_during_clear_ignored");
    load(BASE + 64'd120, 3'd7, 64'd0, "load_last_word");
    idle(2);

    store(BASE, 8'hFF, 64'h1122_3344_5566_7788);
    load(BASE, 3'd7, 64'h1122_3344_5566_7788, "raw_forward_full");
    idle(2);

    store(BASE + 64'd8, 8'hFF, 64'd0);
    store(BASE + 64'd8, 8'h0F, 64'hAAAA_AAAA_DEAD_BEEF);
    load(BASE + 64'd10, 3'd1, 64'h0000_0000_0000_DEAD, "half_at_off2");
    load(BASE + 64'd11, 3'd0, 64'h0000_0000_0000_00DE, "byte_at_off3");
    load(BASE + 64'd8, 3'd7, 64'h0000_0000_DEAD_BEEF, "masked_word");
    idle(2);

    store(BASE + 64'd32, 8'hFF, 64'h0102_0304_0506_0708);
    store(BASE + 64'd32, 8'hF0, 64'hA1A2_A3A4_0000_0000);
    load(BASE + 64'd32, 3'd7, 64'hA1A2_A3A4_0506_0708, "store_store_merge");
    idle(2);
    chk("misalign_clear", {63'd0, misalign_o}, 64'd0);

    load(BASE + 64'd6, 3'd3, 64'h0000_0000_0000_1122, "misaligned_trunc");
    chk("misalign_set", {63'd0, misalign_o}, 64'd1);
    load(BASE, 3'd3, 64'h0000_0000_5566_7788, "aligned_after_mis");
    idle(1);
    chk("misalign_sticky", {63'd0, misalign_o}, 64'd1);

    store(BASE - 64'd8, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD);
    store(BASE + 64'd128, 8'hFF, 64'hBEEF_BEEF_BEEF_BEEF);
    load(BASE - 64'd8, 3'd7, 64'd0, "oow_below");
    load(BASE + 64'd128, 3'd7, 64'd0, "oow_above");
    load(BASE, 3'd7, 64'h1122_3344_5566_7788, "oow_no_alias_w0");
    load(BASE + 64'd120, 3'd7, 64'd0, "oow_no_alias_w15");
    idle(2);

    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        a  = BASE + 64'(8 * $urandom_range(0, 15));
        we = 8'($urandom);
        if (we == 8'd0) we = 8'h01;
        store(a, we, {$urandom, $urandom});
      end else begin
        a  = BASE + 64'($urandom_range(0, 127));
        if (i % 11 == 0) a = BASE + 64'd128 + 64'($urandom_range(0, 63));
        rl = rl_tab[$urandom_range(0, 3)];
        load(a, rl, mload(a, rl), $sformatf("rand_%0d", i));
      end
    end
    idle(2);

    // Reset one cycle after a store: the store is lost and the array re-zeroed
    store(BASE + 64'd16, 8'hFF, 64'hCAFE_F00D_CAFE_F00D);
    resetn = 1'b0;
    step();
    chk("rst2_rdata", dbus_rdata_o, 64'd0);
    chk("rst2_ready", {63'd0, ready_o}, 64'd0);
    chk("rst2_misalign", {63'd0, misalign_o}, 64'd0);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    cnt = 0;
    while (!ready_o && cnt < 40) begin
      step();
      cnt++;
    end
    chk("rst2_clear_cycles", 64'(cnt), 64'd16);
    load(BASE + 64'd16, 3'd7, 64'd0, "store_lost_by_reset");
    load(BASE, 3'd7, 64'd0, "word0_rezeroed");
    idle(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
